// File: rtl/fetch_stage_pkg.sv
// Shared types and defaults for the instruction-fetch stage: datapath width, NOP encoding,
// reset PC and the {pc, instr} entry carried through the fetch queues.
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam int DEFAULT_DEPTH = 2;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: imem request/response, execute redirect and decode handoff.
// master = fetch stage, slave = surrounding memory/execute/decode.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_instr;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_stage_fifo.sv
// Sync FIFO of fetch entries with flush; push visible at head one cycle later (no bypass).
// Backpressure: caller must not push when full unless popping the same cycle.
module fetch_stage_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           push_dat,
  output fetch_entry_t           head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            do_push, do_pop;

  assign full     = (count == DEPTH_W);
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_dat;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_stage.sv
// In-order instruction fetch with credit-limited requests and a squashing redirect.
// Latency accept->id_valid 2 cycles on a 1-cycle memory; stalls requests when the output buffer has no credit.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = DEFAULT_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   inflight, drop_cnt, live, out_count, tag_count;
  logic [CW:0]     used;
  logic            req_fire, rsp_drop, out_push, id_pop;
  logic            tag_full, tag_empty, out_full, out_empty;
  fetch_entry_t    tag_in, tag_head, out_in, out_head;
  logic            unused_sink;

  assign live   = inflight - drop_cnt;
  assign id_pop = !out_empty && bus.id_ready;
  // A slot popped this cycle is reusable now: a new request's response lands no earlier than next cycle.
  assign used   = {1'b0, live} + {1'b0, out_count} - {{CW{1'b0}}, id_pop};

  assign bus.imem_req_valid = !rst && !bus.redirect_valid && (used < DEPTH_W)
                              && (inflight < DEPTH_W[CW-1:0]);
  assign bus.imem_req_addr  = fetch_pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign rsp_drop = bus.imem_rsp_valid && (bus.redirect_valid || drop_cnt != '0);
  assign out_push = bus.imem_rsp_valid && !rsp_drop;

  assign tag_in = '{pc: fetch_pc, instr: '0};
  assign out_in = '{pc: tag_head.pc, instr: bus.imem_rsp_data};

  fetch_stage_fifo #(.DEPTH(DEPTH)) u_tag_q (
    .clk(clk), .rst(rst), .push(req_fire), .pop(bus.imem_rsp_valid), .flush(1'b0),
    .push_dat(tag_in), .head_dat(tag_head), .full(tag_full), .empty(tag_empty), .count(tag_count)
  );

  fetch_stage_fifo #(.DEPTH(DEPTH)) u_out_q (
    .clk(clk), .rst(rst), .push(out_push), .pop(id_pop), .flush(bus.redirect_valid),
    .push_dat(out_in), .head_dat(out_head), .full(out_full), .empty(out_empty), .count(out_count)
  );

  assign unused_sink = ^{tag_full, tag_empty, tag_count, tag_head.instr, out_full,
                         bus.redirect_pc[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      if (bus.redirect_valid) begin
        // No request fires in a redirect cycle, so everything still outstanding must be dropped.
        fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
        drop_cnt <= inflight - CW'(bus.imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (bus.imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  assign bus.id_valid = !out_empty;
  assign bus.id_pc    = out_empty ? '0 : out_head.pc;
  assign bus.id_instr = out_empty ? NOP_INSTR : out_head.instr;

endmodule
